// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: datapath width, queue entry, PC increment.
package if_fetch_queue_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bus bundle: imem request/response channel and the valid/ready handoff to ID.
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Sync FIFO of fetch entries with flush; push-to-head latency 1 cycle, head read from registers.
// No internal backpressure beyond full; a push while full is taken only alongside a pop.
module fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  output fetch_entry_t           head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// In-order prefetcher: credit-limited imem requests, responses queued with PCs; rsp->out 1 cycle.
// Requests stall when in-flight plus queued would overrun the queue; ID stalls via out_ready.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [XLEN-1:0]           redirect_pc,
  if_fetch_queue_if.master          fq,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int              CW        = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C   = (CW + 1)'(FQ_DEPTH);

  logic [XLEN-1:0] req_pc, rsp_pc, redirect_base;
  logic [CW-1:0]   inflight, drop, live;
  logic [CW:0]     credit_use;
  logic            req_fire, rsp_live, fifo_empty;
  fetch_entry_t    push_entry, head_entry;

  assign live          = inflight - drop;
  assign credit_use    = {1'b0, fq_count} + {1'b0, live};
  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Only issue when every live response is guaranteed a queue slot on arrival.
  assign fq.imem_req_valid = !rst && !redirect && (inflight < MAX_OUT_C) && (credit_use < DEPTH_C);
  assign fq.imem_addr      = req_pc;
  assign req_fire          = fq.imem_req_valid && fq.imem_req_ready;
  assign rsp_live          = fq.imem_rsp_valid && (drop == '0) && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old stream and must be drained.
      req_pc   <= redirect_base;
      rsp_pc   <= redirect_base;
      inflight <= inflight - CW'(fq.imem_rsp_valid);
      drop     <= inflight - CW'(fq.imem_rsp_valid);
    end else begin
      if (req_fire) req_pc <= pc_inc(req_pc);
      inflight <= inflight + CW'(req_fire) - CW'(fq.imem_rsp_valid);
      if (fq.imem_rsp_valid) begin
        if (drop != '0) drop <= drop - CW'(1);
        else            rsp_pc <= pc_inc(rsp_pc);
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = rsp_pc;
    push_entry.instr = fq.imem_rsp_data;
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (rsp_live),
    .push_dat (push_entry),
    .pop      (fq.out_valid && fq.out_ready),
    .head_dat (head_entry),
    .empty    (fifo_empty),
    .count    (fq_count)
  );

  assign fq.out_valid = !fifo_empty;
  assign fq.out_pc    = head_entry.pc;
  assign fq.out_instr = head_entry.instr;

endmodule
